// File: rtl/hdr_offset_tracker.sv
// Per-frame byte position tracker with NUM_MARKS header-boundary pulses.
// Reports frame length, runt/oversize and unreached boundaries at frame end.
module hdr_offset_tracker #(
    parameter int DATA_WIDTH      = 64,
    parameter int NUM_MARKS       = 4,
    parameter int CNT_W           = 16,
    parameter int MIN_FRAME_BYTES = 60,
    parameter int MAX_FRAME_BYTES = 1514,
    localparam int BPB            = DATA_WIDTH / 8,
    localparam int LW             = $clog2(BPB + 1)
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       beat_accept,
    input  logic [BPB-1:0]             beat_keep,
    input  logic                       beat_last,
    input  logic                       frame_abort,
    input  logic [NUM_MARKS*CNT_W-1:0] mark_offset,
    output logic                       in_frame,
    output logic [NUM_MARKS-1:0]       mark_done,
    output logic [NUM_MARKS*LW-1:0]    mark_lane,
    output logic                       frame_done,
    output logic [CNT_W-1:0]           frame_len,
    output logic                       runt,
    output logic                       oversize,
    output logic [NUM_MARKS-1:0]       marks_missed
);

    typedef enum logic {
        IDLE,
        ACTIVE
    } state_e;

    localparam logic [CNT_W-1:0] MIN_L = CNT_W'(MIN_FRAME_BYTES);
    localparam logic [CNT_W-1:0] MAX_L = CNT_W'(MAX_FRAME_BYTES);

    state_e                     state_q, state_d;
    logic [CNT_W-1:0]           count_q, count_d;
    logic [NUM_MARKS-1:0]       fired_q, fired_d;
    logic [NUM_MARKS*CNT_W-1:0] offs_q, offs_d;
    logic [NUM_MARKS-1:0]       mark_done_q, mark_done_d;
    logic [NUM_MARKS*LW-1:0]    mark_lane_q, mark_lane_d;
    logic                       frame_done_q, frame_done_d;
    logic [CNT_W-1:0]           frame_len_q, frame_len_d;
    logic                       runt_q, runt_d;
    logic                       oversize_q, oversize_d;
    logic [NUM_MARKS-1:0]       missed_q, missed_d;

    logic                       acc;
    logic                       fin;
    logic [LW-1:0]              beat_bytes;
    logic [CNT_W:0]             n_wide;
    logic [CNT_W-1:0]           n;
    logic [NUM_MARKS*CNT_W-1:0] eff_off;
    logic [NUM_MARKS-1:0]       enabled;
    logic [NUM_MARKS-1:0]       fire;
    logic [NUM_MARKS*LW-1:0]    lane;
    logic [CNT_W-1:0]           off_k;

    // Abort takes priority over a beat presented on the same cycle.
    assign acc = beat_accept & ~frame_abort;
    assign fin = acc & beat_last;

    always_comb begin
        beat_bytes = '0;
        for (int i = 0; i < BPB; i++) begin
            beat_bytes = beat_bytes + LW'(beat_keep[i]);
        end
        n_wide = {1'b0, count_q} + (CNT_W + 1)'(beat_bytes);
        n      = n_wide[CNT_W] ? '1 : n_wide[CNT_W-1:0];
    end

    // Offsets come straight from the port on the SOF beat, latched after.
    assign eff_off = (state_q == IDLE) ? mark_offset : offs_q;

    always_comb begin
        enabled = '0;
        fire    = '0;
        lane    = '0;
        off_k   = '0;
        for (int k = 0; k < NUM_MARKS; k++) begin
            off_k      = eff_off[k*CNT_W +: CNT_W];
            enabled[k] = (off_k != '0);
            fire[k]    = acc & enabled[k] & ~fired_q[k]
                       & (count_q < off_k) & (off_k <= n);
            // Difference never exceeds BPB, so low bits are exact.
            lane[k*LW +: LW] = off_k[LW-1:0] - count_q[LW-1:0];
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (acc && !beat_last) begin
                    state_d = ACTIVE;
                end
            end
            ACTIVE: begin
                if (frame_abort || fin) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        count_d      = count_q;
        fired_d      = fired_q;
        offs_d       = offs_q;
        mark_done_d  = '0;
        mark_lane_d  = mark_lane_q;
        frame_done_d = 1'b0;
        frame_len_d  = frame_len_q;
        runt_d       = runt_q;
        oversize_d   = oversize_q;
        missed_d     = missed_q;

        if (acc && state_q == IDLE) begin
            offs_d = mark_offset;
        end

        if (frame_abort) begin
            count_d = '0;
            fired_d = '0;
        end else if (acc) begin
            mark_done_d = fire;
            for (int k = 0; k < NUM_MARKS; k++) begin
                if (fire[k]) begin
                    mark_lane_d[k*LW +: LW] = lane[k*LW +: LW];
                end
            end
            if (fin) begin
                count_d      = '0;
                fired_d      = '0;
                frame_done_d = 1'b1;
                frame_len_d  = n;
                runt_d       = (n < MIN_L);
                oversize_d   = (n > MAX_L);
                missed_d     = enabled & ~(fired_q | fire);
            end else begin
                count_d = n;
                fired_d = fired_q | fire;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            count_q      <= '0;
            fired_q      <= '0;
            offs_q       <= '0;
            mark_done_q  <= '0;
            mark_lane_q  <= '0;
            frame_done_q <= 1'b0;
            frame_len_q  <= '0;
            runt_q       <= 1'b0;
            oversize_q   <= 1'b0;
            missed_q     <= '0;
        end else begin
            state_q      <= state_d;
            count_q      <= count_d;
            fired_q      <= fired_d;
            offs_q       <= offs_d;
            mark_done_q  <= mark_done_d;
            mark_lane_q  <= mark_lane_d;
            frame_done_q <= frame_done_d;
            frame_len_q  <= frame_len_d;
            runt_q       <= runt_d;
            oversize_q   <= oversize_d;
            missed_q     <= missed_d;
        end
    end

    assign in_frame     = (state_q == ACTIVE);
    assign mark_done    = mark_done_q;
    assign mark_lane    = mark_lane_q;
    assign frame_done   = frame_done_q;
    assign frame_len    = frame_len_q;
    assign runt         = runt_q;
    assign oversize     = oversize_q;
    assign marks_missed = missed_q;

endmodule

// File: tb/tb_hdr_offset_tracker.sv
// Bench for hdr_offset_tracker: directed scenarios with literal expectations
// plus a randomized run against an integer-arithmetic frame model.
module tb_hdr_offset_tracker;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        beat_accept;
    logic [7:0]  beat_keep;
    logic        beat_last;
    logic        frame_abort;
    logic [63:0] mark_offset;
    logic        in_frame;
    logic [3:0]  mark_done;
    logic [15:0] mark_lane;
    logic        frame_done;
    logic [15:0] frame_len;
    logic        runt;
    logic        oversize;
    logic [3:0]  marks_missed;

    int checks = 0;
    int failures = 0;

    int       m_cnt;
    bit [3:0] m_fired;
    int       m_off [4];
    bit       m_active;

    logic [3:0]  e_done;
    logic [15:0] e_lane;
    logic        e_fd;
    logic [15:0] e_len;
    logic        e_runt;
    logic        e_over;
    logic [3:0]  e_missed;
    logic        e_inf;

    hdr_offset_tracker dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .beat_accept  (beat_accept),
        .beat_keep    (beat_keep),
        .beat_last    (beat_last),
        .frame_abort  (frame_abort),
        .mark_offset  (mark_offset),
        .in_frame     (in_frame),
        .mark_done    (mark_done),
        .mark_lane    (mark_lane),
        .frame_done   (frame_done),
        .frame_len    (frame_len),
        .runt         (runt),
        .oversize     (oversize),
        .marks_missed (marks_missed)
    );

    always #5 clk = ~clk;

    task automatic set_offs(input int a, input int b, input int c, input int d);
        mark_offset = {16'(d), 16'(c), 16'(b), 16'(a)};
    endtask

    task automatic model_reset;
        m_cnt    = 0;
        m_fired  = '0;
        m_active = 1'b0;
        for (int k = 0; k < 4; k++) m_off[k] = 0;
        e_done = '0; e_lane = '0; e_fd = 1'b0; e_len = '0;
        e_runt = 1'b0; e_over = 1'b0; e_missed = '0; e_inf = 1'b0;
    endtask

    task automatic do_reset;
        rst_n       = 1'b0;
        beat_accept = 1'b0;
        beat_keep   = '0;
        beat_last   = 1'b0;
        frame_abort = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Drive one cycle and advance the frame model; outputs settle by return.
    task automatic beat(input bit acc, input logic [7:0] keep,
                        input bit last, input bit abort);
        int c, n, off;
        @(negedge clk);
        beat_accept = acc;
        beat_keep   = keep;
        beat_last   = last;
        frame_abort = abort;
        e_done = '0;
        e_fd   = 1'b0;
        if (abort) begin
            m_cnt = 0; m_fired = '0; m_active = 1'b0;
        end else if (acc) begin
            if (!m_active)
                for (int k = 0; k < 4; k++) m_off[k] = int'(mark_offset[k*16 +: 16]);
            c = m_cnt;
            n = c + $countones(keep);
            if (n > 65535) n = 65535;
            for (int k = 0; k < 4; k++) begin
                off = m_off[k];
                if (off != 0 && !m_fired[k] && c < off && off <= n) begin
                    e_done[k] = 1'b1;
                    e_lane[k*4 +: 4] = 4'(off - c);
                    m_fired[k] = 1'b1;
                end
            end
            if (last) begin
                e_fd = 1'b1;
                e_len = 16'(n);
                e_runt = (n < 60);
                e_over = (n > 1514);
                for (int k = 0; k < 4; k++) e_missed[k] = (m_off[k] != 0) && !m_fired[k];
                m_cnt = 0; m_fired = '0; m_active = 1'b0;
            end else begin
                m_cnt = n; m_active = 1'b1;
            end
        end
        e_inf = m_active;
        @(posedge clk);
        #1;
        beat_accept = 1'b0;
        beat_last   = 1'b0;
        frame_abort = 1'b0;
    endtask

    task automatic test_reset;
        do_reset();
        @(posedge clk); #1;
        checks++; if (in_frame !== 1'b0) begin failures++; $display("FAIL rst_in_frame got=%0h exp=0", in_frame); end
        checks++; if (mark_done !== 4'h0) begin failures++; $display("FAIL rst_mark_done got=%0h exp=0", mark_done); end
        checks++; if (mark_lane !== 16'h0) begin failures++; $display("FAIL rst_mark_lane got=%0h exp=0", mark_lane); end
        checks++; if (frame_done !== 1'b0) begin failures++; $display("FAIL rst_frame_done got=%0h exp=0", frame_done); end
        checks++; if (frame_len !== 16'h0) begin failures++; $display("FAIL rst_frame_len got=%0h exp=0", frame_len); end
        checks++; if (runt !== 1'b0) begin failures++; $display("FAIL rst_runt got=%0h exp=0", runt); end
        checks++; if (oversize !== 1'b0) begin failures++; $display("FAIL rst_oversize got=%0h exp=0", oversize); end
        checks++; if (marks_missed !== 4'h0) begin failures++; $display("FAIL rst_missed got=%0h exp=0", marks_missed); end
    endtask

    task automatic test_basic;
        logic [3:0] ed [6];
        ed = '{4'h0, 4'h1, 4'h2, 4'h0, 4'h4, 4'h0};
        set_offs(14, 18, 38, 0);
        for (int i = 0; i < 6; i++) begin
            beat(1'b1, 8'hFF, i == 5, 1'b0);
            checks++;
            if (mark_done !== ed[i]) begin failures++; $display("FAIL basic_done[%0d] got=%0h exp=%0h", i, mark_done, ed[i]); end
            checks++;
            if (in_frame !== (i != 5)) begin failures++; $display("FAIL basic_in_frame[%0d] got=%0h", i, in_frame); end
        end
        checks++; if (mark_lane[11:0] !== 12'h626) begin failures++; $display("FAIL basic_lanes got=%0h exp=626", mark_lane[11:0]); end
        checks++; if (frame_done !== 1'b1) begin failures++; $display("FAIL basic_frame_done got=%0h exp=1", frame_done); end
        checks++; if (frame_len !== 16'd48) begin failures++; $display("FAIL basic_len got=%0d exp=48", frame_len); end
        checks++; if (runt !== 1'b1) begin failures++; $display("FAIL basic_runt got=%0h exp=1", runt); end
        checks++; if (oversize !== 1'b0) begin failures++; $display("FAIL basic_over got=%0h exp=0", oversize); end
        checks++; if (marks_missed !== 4'h0) begin failures++; $display("FAIL basic_missed got=%0h exp=0", marks_missed); end
    endtask

    task automatic test_short;
        logic [3:0] ed [3];
        logic [7:0] kp [3];
        ed = '{4'h0, 4'h1, 4'h2};
        kp = '{8'hFF, 8'hFF, 8'h0F};
        set_offs(14, 18, 38, 0);
        for (int i = 0; i < 3; i++) begin
            beat(1'b1, kp[i], i == 2, 1'b0);
            checks++;
            if (mark_done !== ed[i]) begin failures++; $display("FAIL short_done[%0d] got=%0h exp=%0h", i, mark_done, ed[i]); end
        end
        checks++; if (mark_lane[7:0] !== 8'h26) begin failures++; $display("FAIL short_lanes got=%0h exp=26", mark_lane[7:0]); end
        checks++; if (frame_done !== 1'b1) begin failures++; $display("FAIL short_frame_done got=%0h exp=1", frame_done); end
        checks++; if (frame_len !== 16'd20) begin failures++; $display("FAIL short_len got=%0d exp=20", frame_len); end
        checks++; if (runt !== 1'b1) begin failures++; $display("FAIL short_runt got=%0h exp=1", runt); end
        checks++; if (oversize !== 1'b0) begin failures++; $display("FAIL short_over got=%0h exp=0", oversize); end
        checks++; if (marks_missed !== 4'b0100) begin failures++; $display("FAIL short_missed got=%0h exp=4", marks_missed); end
    endtask

    task automatic test_oversize;
        int cnt [4];
        int ec [4];
        cnt = '{default: 0};
        ec  = '{1, 1, 1, 0};
        set_offs(14, 18, 38, 0);
        for (int i = 0; i < 190; i++) begin
            beat(1'b1, 8'hFF, i == 189, 1'b0);
            for (int k = 0; k < 4; k++) cnt[k] += int'(mark_done[k]);
        end
        checks++; if (frame_done !== 1'b1) begin failures++; $display("FAIL over_frame_done got=%0h exp=1", frame_done); end
        checks++; if (frame_len !== 16'd1520) begin failures++; $display("FAIL over_len got=%0d exp=1520", frame_len); end
        checks++; if (oversize !== 1'b1) begin failures++; $display("FAIL over_over got=%0h exp=1", oversize); end
        checks++; if (runt !== 1'b0) begin failures++; $display("FAIL over_runt got=%0h exp=0", runt); end
        checks++; if (marks_missed !== 4'h0) begin failures++; $display("FAIL over_missed got=%0h exp=0", marks_missed); end
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (cnt[k] !== ec[k]) begin failures++; $display("FAIL over_pulses[%0d] got=%0d exp=%0d", k, cnt[k], ec[k]); end
        end
    endtask

    task automatic test_abort;
        set_offs(14, 18, 38, 0);
        for (int i = 0; i < 3; i++) beat(1'b1, 8'hFF, 1'b0, 1'b0);
        beat(1'b1, 8'hFF, 1'b1, 1'b1);
        checks++; if (frame_done !== 1'b0) begin failures++; $display("FAIL abort_frame_done got=%0h exp=0", frame_done); end
        checks++; if (mark_done !== 4'h0) begin failures++; $display("FAIL abort_done got=%0h exp=0", mark_done); end
        checks++; if (in_frame !== 1'b0) begin failures++; $display("FAIL abort_in_frame got=%0h exp=0", in_frame); end
        beat(1'b0, 8'h00, 1'b0, 1'b0);
        checks++; if (frame_done !== 1'b0) begin failures++; $display("FAIL abort_idle_fd got=%0h exp=0", frame_done); end
        beat(1'b1, 8'hFF, 1'b0, 1'b0);
        checks++; if (mark_done !== 4'h0) begin failures++; $display("FAIL abort_b0_done got=%0h exp=0", mark_done); end
        beat(1'b1, 8'hFF, 1'b1, 1'b0);
        checks++; if (mark_done !== 4'b0001) begin failures++; $display("FAIL abort_b1_done got=%0h exp=1", mark_done); end
        checks++; if (mark_lane[3:0] !== 4'd6) begin failures++; $display("FAIL abort_lane got=%0d exp=6", mark_lane[3:0]); end
        checks++; if (frame_len !== 16'd16) begin failures++; $display("FAIL abort_len got=%0d exp=16", frame_len); end
        checks++; if (marks_missed !== 4'b0110) begin failures++; $display("FAIL abort_missed got=%0h exp=6", marks_missed); end
    endtask

    task automatic test_offset_latch;
        set_offs(8, 8, 16, 0);
        beat(1'b1, 8'hFF, 1'b0, 1'b0);
        checks++; if (mark_done !== 4'b0011) begin failures++; $display("FAIL latch_b0_done got=%0h exp=3", mark_done); end
        checks++; if (mark_lane[7:0] !== 8'h88) begin failures++; $display("FAIL latch_b0_lanes got=%0h exp=88", mark_lane[7:0]); end
        set_offs(4, 8, 16, 0);
        beat(1'b1, 8'hFF, 1'b0, 1'b0);
        checks++; if (mark_done !== 4'b0100) begin failures++; $display("FAIL latch_b1_done got=%0h exp=4", mark_done); end
        checks++; if (mark_lane[11:8] !== 4'd8) begin failures++; $display("FAIL latch_b1_lane got=%0d exp=8", mark_lane[11:8]); end
        beat(1'b1, 8'hFF, 1'b1, 1'b0);
        checks++; if (mark_done !== 4'h0) begin failures++; $display("FAIL latch_b2_done got=%0h exp=0", mark_done); end
        checks++; if (frame_len !== 16'd24) begin failures++; $display("FAIL latch_len got=%0d exp=24", frame_len); end
        beat(1'b1, 8'hFF, 1'b1, 1'b0);
        checks++; if (mark_done !== 4'b0011) begin failures++; $display("FAIL latch_next_done got=%0h exp=3", mark_done); end
        checks++; if (mark_lane[7:0] !== 8'h84) begin failures++; $display("FAIL latch_next_lanes got=%0h exp=84", mark_lane[7:0]); end
        checks++; if (marks_missed !== 4'b0100) begin failures++; $display("FAIL latch_next_missed got=%0h exp=4", marks_missed); end
    endtask

    task automatic test_back_to_back;
        set_offs(14, 18, 38, 0);
        beat(1'b1, 8'hFF, 1'b1, 1'b0);
        checks++; if (frame_done !== 1'b1) begin failures++; $display("FAIL b2b_fd got=%0h exp=1", frame_done); end
        checks++; if (frame_len !== 16'd8) begin failures++; $display("FAIL b2b_len got=%0d exp=8", frame_len); end
        checks++; if (in_frame !== 1'b0) begin failures++; $display("FAIL b2b_in_frame got=%0h exp=0", in_frame); end
        checks++; if (marks_missed !== 4'b0111) begin failures++; $display("FAIL b2b_missed got=%0h exp=7", marks_missed); end
        beat(1'b1, 8'hFF, 1'b0, 1'b0);
        checks++; if (frame_done !== 1'b0) begin failures++; $display("FAIL b2b_sof_fd got=%0h exp=0", frame_done); end
        checks++; if (in_frame !== 1'b1) begin failures++; $display("FAIL b2b_sof_in_frame got=%0h exp=1", in_frame); end
        beat(1'b1, 8'hFF, 1'b0, 1'b0);
        checks++; if (mark_done !== 4'b0001) begin failures++; $display("FAIL b2b_b1_done got=%0h exp=1", mark_done); end
        #2 rst_n = 1'b0;
        model_reset();
        #1;
        checks++; if (in_frame !== 1'b0) begin failures++; $display("FAIL mrst_in_frame got=%0h exp=0", in_frame); end
        checks++; if (mark_done !== 4'h0) begin failures++; $display("FAIL mrst_done got=%0h exp=0", mark_done); end
        checks++; if (mark_lane !== 16'h0) begin failures++; $display("FAIL mrst_lane got=%0h exp=0", mark_lane); end
        checks++; if (frame_len !== 16'h0) begin failures++; $display("FAIL mrst_len got=%0h exp=0", frame_len); end
        checks++; if (runt !== 1'b0 || oversize !== 1'b0) begin failures++; $display("FAIL mrst_flags got=%0h%0h exp=00", runt, oversize); end
        checks++; if (marks_missed !== 4'h0 || frame_done !== 1'b0) begin failures++; $display("FAIL mrst_missed_fd got=%0h/%0h exp=0/0", marks_missed, frame_done); end
        @(negedge clk);
        rst_n = 1'b1;
        beat(1'b1, 8'hFF, 1'b0, 1'b0);
        checks++; if (mark_done !== 4'h0) begin failures++; $display("FAIL post_b0_done got=%0h exp=0", mark_done); end
        beat(1'b1, 8'hFF, 1'b1, 1'b0);
        checks++; if (mark_done !== 4'b0001) begin failures++; $display("FAIL post_b1_done got=%0h exp=1", mark_done); end
        checks++; if (frame_len !== 16'd16) begin failures++; $display("FAIL post_len got=%0d exp=16", frame_len); end
    endtask

    task automatic test_saturate;
        int pulses = 0;
        set_offs(14, 0, 0, 0);
        for (int i = 0; i < 8200; i++) begin
            beat(1'b1, 8'hFF, i == 8199, 1'b0);
            pulses += int'(mark_done[0]);
        end
        checks++; if (frame_len !== 16'hFFFF) begin failures++; $display("FAIL sat_len got=%0h exp=ffff", frame_len); end
        checks++; if (oversize !== 1'b1 || frame_done !== 1'b1) begin failures++; $display("FAIL sat_over_fd got=%0h/%0h exp=1/1", oversize, frame_done); end
        checks++; if (pulses !== 1) begin failures++; $display("FAIL sat_pulses got=%0d exp=1", pulses); end
    endtask

    task automatic test_random;
        bit acc, last, abort;
        logic [7:0] keep;
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 15) == 0)
                set_offs(($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(1, 120)),
                         ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(1, 120)),
                         ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(1, 120)),
                         ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(1, 120)));
            acc   = ($urandom_range(0, 3) != 0);
            keep  = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
            last  = ($urandom_range(0, 7) == 0);
            abort = ($urandom_range(0, 31) == 0);
            beat(acc, keep, last, abort);
            checks++; if (mark_done !== e_done) begin failures++; $display("FAIL rnd_done[%0d] got=%0h exp=%0h", i, mark_done, e_done); end
            checks++; if (mark_lane !== e_lane) begin failures++; $display("FAIL rnd_lane[%0d] got=%0h exp=%0h", i, mark_lane, e_lane); end
            checks++; if (frame_done !== e_fd) begin failures++; $display("FAIL rnd_fd[%0d] got=%0h exp=%0h", i, frame_done, e_fd); end
            checks++; if (in_frame !== e_inf) begin failures++; $display("FAIL rnd_in_frame[%0d] got=%0h exp=%0h", i, in_frame, e_inf); end
            checks++; if (frame_len !== e_len) begin failures++; $display("FAIL rnd_len[%0d] got=%0d exp=%0d", i, frame_len, e_len); end
            if (e_fd) begin
                checks++; if (runt !== e_runt) begin failures++; $display("FAIL rnd_runt[%0d] got=%0h exp=%0h", i, runt, e_runt); end
                checks++; if (oversize !== e_over) begin failures++; $display("FAIL rnd_over[%0d] got=%0h exp=%0h", i, oversize, e_over); end
                checks++; if (marks_missed !== e_missed) begin failures++; $display("FAIL rnd_missed[%0d] got=%0h exp=%0h", i, marks_missed, e_missed); end
            end
        end
    endtask

    initial begin
        mark_offset = '0;
        test_reset();
        test_basic();
        test_short();
        test_oversize();
        test_abort();
        test_offset_latch();
        test_back_to_back();
        test_saturate();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
